// File: rtl/gpu_io_master.sv
// gpu_io_master: splits a 32-bit request into two strobed 16-bit bus cycles separated by an idle gap,
// aborting a strobe that waits TIMEOUT cycles without io_ack.
module gpu_io_master #(
  parameter int IDLE_GAP = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        big_io,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [31:0] rsp_rdata,
  output logic [15:0] io_addr,
  output logic [15:0] io_wdata,
  output logic        iord,
  output logic        iowr,
  input  logic        io_ack,
  input  logic [15:0] io_rdata
);
  typedef enum logic [2:0] {IDLE, CYC0, GAP, CYC1, DONE} state_t;
  localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0] LP_GAP_LAST = 3'(IDLE_GAP - 1);
  state_t      r_state;
  logic        r_write;
  logic        r_big;
  logic [15:0] r_wdata1;
  logic [15:0] r_word0;
  logic [7:0]  r_cnt;
  logic [2:0]  r_gap;
  logic        w_timeout;
  logic        w_unused;
  assign w_timeout = r_cnt == LP_CNT_LAST;
  assign w_unused  = ^req_addr[1:0];
  // ack is checked before the timeout so an ack on the last allowed cycle still succeeds
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      req_ready <= 1'b0;
      r_write   <= 1'b0;
      r_big     <= 1'b0;
      r_wdata1  <= '0;
      r_word0   <= '0;
      r_cnt     <= '0;
      r_gap     <= '0;
      io_addr   <= '0;
      io_wdata  <= '0;
      iord      <= 1'b0;
      iowr      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r_state   <= CYC0;
            req_ready <= 1'b0;
            r_write   <= req_write;
            r_big     <= big_io;
            r_wdata1  <= big_io ? req_wdata[15:0] : req_wdata[31:16];
            r_cnt     <= '0;
            io_addr   <= {req_addr[15:2], 2'b00};
            io_wdata  <= req_write ? (big_io ? req_wdata[31:16] : req_wdata[15:0]) : 16'h0;
            iord      <= ~req_write;
            iowr      <= req_write;
          end else begin
            req_ready <= 1'b1;
          end
        end
        CYC0: begin
          if (io_ack) begin
            r_state  <= GAP;
            r_gap    <= '0;
            r_word0  <= r_write ? 16'h0 : io_rdata;
            iord     <= 1'b0;
            iowr     <= 1'b0;
            io_wdata <= '0;
          end else if (w_timeout) begin
            r_state   <= DONE;
            iord      <= 1'b0;
            iowr      <= 1'b0;
            io_wdata  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        GAP: begin
          if (r_gap == LP_GAP_LAST) begin
            r_state    <= CYC1;
            r_cnt      <= '0;
            io_addr[1] <= 1'b1;
            io_wdata   <= r_write ? r_wdata1 : 16'h0;
            iord       <= ~r_write;
            iowr       <= r_write;
          end else begin
            r_gap <= r_gap + 3'd1;
          end
        end
        CYC1: begin
          if (io_ack) begin
            r_state   <= DONE;
            iord      <= 1'b0;
            iowr      <= 1'b0;
            io_wdata  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= r_write ? 32'h0 : (r_big ? {r_word0, io_rdata} : {io_rdata, r_word0});
          end else if (w_timeout) begin
            r_state   <= DONE;
            iord      <= 1'b0;
            iowr      <= 1'b0;
            io_wdata  <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          req_ready <= 1'b1;
          r_word0   <= '0;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpu_io_master.sv
// tb_gpu_io_master: random and directed requests; a bus-slave model and a response monitor check against
// queued expectations computed from the request and the planned ack delays.
module tb_gpu_io_master;
  localparam int GAP = 1;
  localparam int TO  = 4;
  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        big_io = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, iord, iowr;
  logic [31:0] rsp_rdata;
  logic [15:0] io_addr, io_wdata;
  logic        io_ack = 1'b0;
  logic [15:0] io_rdata = '0;
  typedef struct {logic [15:0] addr; logic [15:0] wdata; logic wr; int d; logic [15:0] rd;} strobe_t;
  typedef struct {logic err; logic [31:0] rdata; int cyc;} rsp_t;
  strobe_t sq[$];
  rsp_t    rq[$];
  strobe_t cur;
  rsp_t    rexp;
  int      checks = 0;
  int      failures = 0;
  int      cyc = 0;
  int      last_rsp = -10;
  int      k = 0;
  int      n_wait;
  logic    active = 1'b0;
  logic    bogus = 1'b0;
  logic    prev_hold = 1'b0;

  gpu_io_master #(.IDLE_GAP(GAP), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .big_io(big_io),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .io_addr(io_addr), .io_wdata(io_wdata), .iord(iord), .iowr(iowr),
    .io_ack(io_ack), .io_rdata(io_rdata)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endfunction

  function automatic void fail_evt(string name, logic [31:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h expected=none", name, act);
  endfunction

  // bus slave: acks each strobe after its planned number of wait cycles, checks address/data/length
  always @(negedge sys_clk) begin
    if (!reset_n) begin
      active = 1'b0;
      io_ack = 1'b0;
    end else if (iord || iowr) begin
      if (!active) begin
        active = 1'b1;
        k = 0;
        bogus = (sq.size() == 0);
        if (bogus) begin
          fail_evt("unexpected_strobe", io_addr);
          cur.d = 0;
        end else cur = sq.pop_front();
      end
      if (!bogus) begin
        chk("io_addr", io_addr, cur.addr);
        chk("io_wdata", io_wdata, cur.wdata);
        chk("iowr", iowr, cur.wr);
        chk("iord", iord, !cur.wr);
      end
      io_ack = (k == cur.d);
      io_rdata = io_ack ? cur.rd : 16'($urandom);
      k++;
    end else begin
      if (active && !bogus) chk("strobe_len", k, (cur.d < TO) ? cur.d + 1 : TO);
      active = 1'b0;
      chk("io_wdata_idle", io_wdata, 0);
      io_ack = 1'($urandom_range(0, 1));
      io_rdata = 16'($urandom);
    end
  end

  always @(negedge sys_clk) begin
    if (reset_n && rsp_valid) begin
      if (rq.size() == 0) fail_evt("unexpected_rsp", rsp_rdata);
      else begin
        rexp = rq.pop_front();
        chk("rsp_err", rsp_err, rexp.err);
        chk("rsp_rdata", rsp_rdata, rexp.rdata);
        chk("rsp_cycle", cyc, rexp.cyc);
      end
      last_rsp = cyc;
    end
  end

  task automatic do_req(input logic wr, input logic [15:0] a, input logic [31:0] wd, input logic bg,
                        input int d0, input int d1, input logic [15:0] r0, input logic [15:0] r1,
                        input logic hold);
    int n;
    rsp_t e;
    logic [15:0] w0, w1;
    w0 = bg ? wd[31:16] : wd[15:0];
    w1 = bg ? wd[15:0] : wd[31:16];
    @(negedge sys_clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = wd;
    big_io = bg;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    if (!req_ready) begin
      fail_evt("accept_timeout", n);
      req_valid = 1'b0;
      prev_hold = 1'b0;
      return;
    end
    if (prev_hold) chk("b2b_accept_cycle", cyc, last_rsp + 1);
    sq.push_back('{addr: {a[15:2], 2'b00}, wdata: wr ? w0 : 16'h0, wr: wr, d: d0, rd: r0});
    if (d0 < TO) sq.push_back('{addr: {a[15:2], 2'b10}, wdata: wr ? w1 : 16'h0, wr: wr, d: d1, rd: r1});
    if (d0 >= TO) e = '{err: 1'b1, rdata: 32'h0, cyc: cyc + TO + 1};
    else if (d1 >= TO) e = '{err: 1'b1, rdata: 32'h0, cyc: cyc + d0 + 1 + GAP + TO + 1};
    else e = '{err: 1'b0, rdata: wr ? 32'h0 : (bg ? {r0, r1} : {r1, r0}), cyc: cyc + d0 + 1 + GAP + d1 + 1 + 1};
    rq.push_back(e);
    @(posedge sys_clk);
    #1;
    req_valid = hold;
    req_write = ~wr;
    req_addr = ~a;
    req_wdata = $urandom;
    big_io = ~bg;
    prev_hold = hold;
  endtask

  initial begin
    repeat (3) @(negedge sys_clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_iord", iord, 0);
    chk("rst_iowr", iowr, 0);
    chk("rst_io_addr", io_addr, 0);
    chk("rst_io_wdata", io_wdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    #1 chk("rel_req_ready_low", req_ready, 0);
    @(negedge sys_clk);
    chk("rel_req_ready_high", req_ready, 1);
    do_req(1'b1, 16'hF104, 32'h12345678, 1'b0, 0, 0, 16'h0, 16'h0, 1'b0);
    do_req(1'b0, 16'h2208, 32'h0, 1'b1, 2, 2, 16'hAAAA, 16'h5555, 1'b0);
    do_req(1'b0, 16'h0010, 32'h0, 1'b0, 9, 0, 16'h0, 16'h0, 1'b0);
    do_req(1'b0, 16'h0020, 32'h0, 1'b0, 3, 3, 16'h1111, 16'h2222, 1'b0);
    do_req(1'b1, 16'h0030, 32'hCAFEBABE, 1'b1, 1, 9, 16'h0, 16'h0, 1'b0);
    do_req(1'b1, 16'h1234, 32'hDEADBEEF, 1'b0, 1, 0, 16'h0, 16'h0, 1'b1);
    do_req(1'b0, 16'h5678, 32'h0, 1'b1, 0, 1, 16'hBEEF, 16'hF00D, 1'b0);
    // abort a write during its second strobe
    do_req(1'b1, 16'h4444, 32'h89ABCDEF, 1'b0, 0, 5, 16'h0, 16'h0, 1'b0);
    n_wait = 0;
    while (!(iowr && io_addr[1]) && n_wait < 50) begin
      @(negedge sys_clk);
      n_wait++;
    end
    chk("reached_cyc1", iowr && io_addr[1], 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_iowr", iowr, 0);
    chk("arst_iord", iord, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_io_addr", io_addr, 0);
    chk("arst_io_wdata", io_wdata, 0);
    sq.delete();
    rq.delete();
    prev_hold = 1'b0;
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    #1 chk("arel_req_ready_low", req_ready, 0);
    @(negedge sys_clk);
    chk("arel_req_ready_high", req_ready, 1);
    for (int i = 0; i < 150; i++)
      do_req(1'($urandom_range(0, 1)), 16'($urandom), $urandom, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 16'($urandom), 16'($urandom),
             1'($urandom_range(0, 1)));
    req_valid = 1'b0;
    n_wait = 0;
    while ((rq.size() != 0 || sq.size() != 0) && n_wait < 200) begin
      @(negedge sys_clk);
      n_wait++;
    end
    chk("drain_rsp", rq.size(), 0);
    chk("drain_strobes", sq.size(), 0);
    repeat (5) @(negedge sys_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gpu_io_master.md
GPU_IO_MASTER -- requirements
Module: gpu_io_master

Interface
REQ-001 SHALL have parameter IDLE_GAP, default 1, meaning the number of idle cycles (range 1-7) between the first and second 16-bit bus cycles.
REQ-002 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of strobe cycles (range 1-255) without io_ack before a cycle is aborted.
REQ-003 SHALL have ports: sys_clk in 1, the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have ports: reset_n in 1, the reset, which is asynchronous and active-low.
REQ-005 SHALL have ports: req_valid in 1 (request present); req_ready out 1 (request accepted this cycle when high with req_valid); req_write in 1 (1=write, 0=read).
REQ-006 SHALL have ports: req_addr in 16 (long-word byte address; bits 1:0 ignored); req_wdata in 32 (write data); big_io in 1 (word order select).
REQ-007 SHALL have ports: rsp_valid out 1 (one-cycle completion pulse); rsp_err out 1 (timeout flag, valid with rsp_valid); rsp_rdata out 32 (read data, valid with rsp_valid).
REQ-008 SHALL have ports: io_addr out 16; io_wdata out 16; iord out 1; iowr out 1; io_ack in 1 (cycle complete); io_rdata in 16 (read word, valid with io_ack).

Function
REQ-009 SHALL implement an FSM with states IDLE, CYC0, GAP, CYC1 and DONE.
REQ-010 SHALL drive req_ready=1 only in IDLE, and SHALL register req_write, req_addr, req_wdata and big_io on acceptance; later input changes SHALL have no effect on the transaction in progress.
REQ-011 SHALL transition IDLE->CYC0 on acceptance, CYC0->GAP on io_ack, GAP->CYC1 after exactly IDLE_GAP cycles, CYC1->DONE on io_ack, and DONE->IDLE unconditionally after one cycle.
REQ-012 SHALL drive all bus outputs from registers, and SHALL drive iord=~write and iowr=write only in CYC0 and CYC1, holding the strobe until the cycle in which io_ack is sampled high.
REQ-013 SHALL ignore io_ack in IDLE, GAP and DONE.
REQ-014 SHALL drive io_addr[15:2]=req_addr[15:2], io_addr[0]=0, io_addr[1]=0 in CYC0 and io_addr[1]=1 in CYC1, holding io_addr stable for the entire strobe.
REQ-015 SHALL, with big_io=0, send wdata[15:0] in CYC0 and wdata[31:16] in CYC1; with big_io=1, SHALL send wdata[31:16] in CYC0 and wdata[15:0] in CYC1.
REQ-016 SHALL drive io_wdata to 0 when not in a write strobe.
REQ-017 SHALL capture io_rdata on the io_ack cycle of each read strobe and SHALL assemble rsp_rdata with the same word mapping as REQ-015.
REQ-018 SHALL drive rsp_rdata=0 for writes.
REQ-019 SHALL assert rsp_valid for exactly one cycle, in DONE.
REQ-020 SHALL give, with io_ack high in the first strobe cycle and IDLE_GAP=1, the sequence: accept at edge 0, CYC0 in cycle 1, GAP in cycle 2, CYC1 in cycle 3, rsp_valid in cycle 4; each wait state SHALL add one cycle.
REQ-021 SHALL count strobe cycles with a counter reset at each strobe start; if TIMEOUT cycles elapse without io_ack, it SHALL drop the strobe and go to DONE with rsp_err=1 and rsp_rdata=0, and SHALL skip CYC1 when the timeout occurs in CYC0.
REQ-022 SHALL treat io_ack arriving in the same cycle the counter reaches TIMEOUT as success (ack wins).
REQ-023 SHALL accept back-to-back requests: req_ready SHALL rise in the cycle after DONE, with no overlap of transactions.

Reset
REQ-024 SHALL, while reset_n=0, force immediately (asynchronously): state=IDLE, iord=iowr=0, io_addr=0, io_wdata=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, counters=0; req_ready SHALL be 0 during reset and 1 in the first cycle after release.
REQ-025 SHALL, on reset asserted mid-transaction, drop the strobe in the same cycle, SHALL NOT produce a response for the aborted request, and SHALL retain no partial data.

Verification
REQ-026 SHALL be verified with: write addr=0xF104, wdata=0x12345678, big_io=0, immediate ack -> CYC0 io_addr=0xF104 io_wdata=0x5678; CYC1 io_addr=0xF106 io_wdata=0x1234; rsp_valid in cycle 4, rsp_err=0.
REQ-027 SHALL be verified with: read, big_io=1, io_rdata=0xAAAA on word 0 and 0x5555 on word 1, 2 wait states each -> rsp_rdata=0xAAAA5555, iord held 3 cycles per word.
REQ-028 SHALL be verified with: TIMEOUT=4, io_ack never asserted -> iord drops after 4 cycles, no CYC1, rsp_valid=1, rsp_err=1, rsp_rdata=0.
REQ-029 SHALL be verified with: io_ack on the 4th cycle, TIMEOUT=4 -> success, rsp_err=0.
REQ-030 SHALL be verified with: reset_n low during CYC1 of a write -> iowr=0 immediately, no rsp_valid, req_ready=1 one cycle after release.
REQ-031 SHALL be verified with: req_valid held high for two requests, req_addr changed mid-transaction -> first transaction uses the original address; second accepted the cycle after DONE.
